pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS core, replacing the plain increment-only PC register. Each cycle it selects the next fetch address from sequential, branch, jump, call and return sources, with stall and a configurable reset vector. It also keeps an optional shadow call stack that checks every return address against the address pushed by the matching call. It sits between the controller/datapath (branch, jump and return requests) and instruction memory (`pc`).

---
 rtl/pc_unit.sv | 134 +++++++++++++
 tb/tb_pc_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (sequential/branch/jump/call/return) with stall.
// Define PC_SHADOW_STACK_EN to build the shadow call stack that checks return targets.
module pc_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             branch,
    input  logic                             zero,
    input  logic [15:0]                      imm,
    input  logic                             jump,
    input  logic                             call,
    input  logic [25:0]                      jtarget,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                ret_addr,
    output logic [ADDR_W-1:0]                pc,
    output logic [ADDR_W-1:0]                pc_plus,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ret_miss
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(32'h0FFF_FFFF);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;

    assign pc         = pc_q;
    assign pc_plus    = pc_q + ADDR_W'(3'd4);
    assign br_target  = pc_plus + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    // Jump keeps the upper bits of the sequential address (works for ADDR_W == 28 too).
    assign jmp_target = (pc_plus & ~LO_MASK) | ADDR_W'({jtarget, 2'b00});

    // Next-PC selection, highest priority first; call implies jump.
    always_comb begin
        pc_d = pc_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            pc_d = ret_addr;
        end else if (call || jump) begin
            pc_d = jmp_target;
        end else if (branch && zero) begin
            pc_d = br_target;
        end else begin
            pc_d = pc_plus;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_SHADOW_STACK_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  tp_q, tp_d;
    logic [PTR_W-1:0]  push_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              miss_q, miss_d;

    assign push_idx     = tp_q + PTR_W'(1'b1);
    assign ras_count    = cnt_q;
    assign ras_overflow = ovf_q;
    assign ret_miss     = miss_q;

    // Shadow stack update: a return pops (and wins over a call), a call pushes; stall freezes all.
    always_comb begin
        ras_d  = ras_q;
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        miss_d = 1'b0;
        if (stall) begin
            miss_d = 1'b0;
        end else if (ret) begin
            if (cnt_q != {CNT_W{1'b0}}) begin
                miss_d = (ras_q[tp_q] != ret_addr);
                cnt_d  = cnt_q - CNT_W'(1'b1);
                tp_d   = tp_q - PTR_W'(1'b1);
            end else begin
                miss_d = 1'b1;
            end
        end else if (call) begin
            ras_d[push_idx] = pc_plus;
            tp_d            = push_idx;
            if (cnt_q < CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1'b1);
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            miss_d = 1'b0;
        end
    end

    // Shadow stack state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= {ADDR_W{1'b0}};
            end
            tp_q   <= {PTR_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            ovf_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            ras_q  <= ras_d;
            tp_q   <= tp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            miss_q <= miss_d;
        end
    end
`else
    assign ras_count    = {CNT_W{1'b0}};
    assign ras_overflow = 1'b0;
    assign ret_miss     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; expected state is queued per step and checked after each edge.
// Stack expectations follow PC_SHADOW_STACK_EN when it is defined for the whole build.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch, zero, jump, call, ret;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic [31:0] ret_addr;
    logic [31:0] pc, pc_plus;
    logic [2:0]  ras_count;
    logic        ras_overflow, ret_miss;

`ifdef PC_SHADOW_STACK_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        miss;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    int    checks = 0;
    int    errors = 0;
    logic  ovf_e  = 1'b0;

    pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero), .imm(imm),
        .jump(jump), .call(call), .jtarget(jtarget), .ret(ret), .ret_addr(ret_addr),
        .pc(pc), .pc_plus(pc_plus), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ret_miss(ret_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] ec(input int n);
        return SS ? 3'(n) : 3'd0;
    endfunction

    function automatic logic em(input bit m);
        return SS ? m : 1'b0;
    endfunction

    task automatic expect_state(input string tag, input logic [31:0] epc,
                                input logic [2:0] ecnt, input logic emiss);
        exp_t e;
        e.pc = epc; e.cnt = ecnt; e.ovf = ovf_e; e.miss = emiss;
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic check_now();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard empty at time %0t", $time);
            return;
        end
        e = sb.pop_front();
        t = tq.pop_front();
        checks++;
        assert (pc === e.pc) else begin
            errors++; $error("FAIL %s pc observed=%h expected=%h", t, pc, e.pc);
        end
        checks++;
        assert (pc_plus === e.pc + 32'd4) else begin
            errors++; $error("FAIL %s pc_plus observed=%h expected=%h", t, pc_plus, e.pc + 32'd4);
        end
        checks++;
        assert (ras_count === e.cnt) else begin
            errors++; $error("FAIL %s ras_count observed=%0d expected=%0d", t, ras_count, e.cnt);
        end
        checks++;
        assert (ras_overflow === e.ovf) else begin
            errors++; $error("FAIL %s ras_overflow observed=%b expected=%b", t, ras_overflow, e.ovf);
        end
        checks++;
        assert (ret_miss === e.miss) else begin
            errors++; $error("FAIL %s ret_miss observed=%b expected=%b", t, ret_miss, e.miss);
        end
    endtask

    // One clocked step: drive all request inputs, queue expectation, check #1 after the edge.
    task automatic step(input string tag, input logic s, input logic b, input logic z,
                        input logic [15:0] im, input logic j, input logic c,
                        input logic [25:0] jt, input logic r, input logic [31:0] ra,
                        input logic [31:0] epc, input logic [2:0] ecnt, input logic emiss);
        stall = s; branch = b; zero = z; imm = im; jump = j; call = c;
        jtarget = jt; ret = r; ret_addr = ra;
        expect_state(tag, epc, ecnt, emiss);
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic seq(input string tag, input logic [31:0] epc,
                       input logic [2:0] ecnt);
        step(tag, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, epc, ecnt, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0; imm = 16'h0;
        jump = 1'b0; call = 1'b0; jtarget = 26'h0; ret = 1'b0; ret_addr = 32'h0;
        #2;
        expect_state("reset", 32'h0, 3'd0, 1'b0);
        check_now();
        @(negedge clk);
        rst = 1'b0;
        seq("seq1", 32'h4, 3'd0);
        seq("seq2", 32'h8, 3'd0);
        seq("seq3", 32'hC, 3'd0);

        // Asynchronous reset between edges.
        #2; rst = 1'b1; #1;
        expect_state("async_rst", 32'h0, 3'd0, 1'b0);
        check_now();
        #1; rst = 1'b0;
        seq("post_rst1", 32'h4, 3'd0);
        seq("post_rst2", 32'h8, 3'd0);
        seq("post_rst3", 32'hC, 3'd0);
        seq("post_rst4", 32'h10, 3'd0);

        // Branches.
        step("br_taken", 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'hC, 3'd0, 1'b0);
        seq("to_10", 32'h10, 3'd0);
        step("br_not_taken", 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h14, 3'd0, 1'b0);

        // Jump keeps upper nibble of pc_plus; branch&zero ignored.
        step("ret_to_4000", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h4000_0010, 32'h4000_0010, 3'd0, em(1'b1));
        step("jump_wrap", 1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0, 26'h0000100, 1'b0, 32'h0, 32'h4000_0400, 3'd0, 1'b0);

        // Call / return.
        step("ret_to_20", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h20, 32'h20, 3'd0, em(1'b1));
        step("call", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'h40, 1'b0, 32'h0, 32'h100, ec(1), 1'b0);
        step("ret_match", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h24, 32'h24, 3'd0, 1'b0);
        step("ret_underflow", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h24, 32'h24, 3'd0, em(1'b1));
        seq("miss_pulse_end", 32'h28, 3'd0);
        step("jump_as_call", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 26'h40, 1'b0, 32'h0, 32'h100, 3'd0, 1'b0);
        step("ret_to_28", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h28, 32'h28, 3'd0, em(1'b1));

        // Five nested calls into a four-entry stack.
        step("call1", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'h80, 1'b0, 32'h0, 32'h200, ec(1), 1'b0);
        step("call2", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'h90, 1'b0, 32'h0, 32'h240, ec(2), 1'b0);
        step("call3", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'hA0, 1'b0, 32'h0, 32'h280, ec(3), 1'b0);
        step("call4", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'hB0, 1'b0, 32'h0, 32'h2C0, ec(4), 1'b0);
        ovf_e = SS;
        step("call5_ovf", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'hC0, 1'b0, 32'h0, 32'h300, ec(4), 1'b0);
        step("ret5", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h2C4, 32'h2C4, ec(3), 1'b0);
        step("ret4", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h284, 32'h284, ec(2), 1'b0);
        step("ret3", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h244, 32'h244, ec(1), 1'b0);
        step("ret2", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h204, 32'h204, 3'd0, 1'b0);
        step("ret1_lost", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h2C, 32'h2C, 3'd0, em(1'b1));

        // Stall freezes pc and stack, mismatching return while stalled raises nothing.
        step("call_s", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'h100, 1'b0, 32'h0, 32'h400, ec(1), 1'b0);
        step("stall_call", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'h200, 1'b0, 32'h0, 32'h400, ec(1), 1'b0);
        step("stall_ret", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h999, 32'h400, ec(1), 1'b0);
        step("ret_mismatch", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h500, 32'h500, 3'd0, em(1'b1));
        seq("after_mismatch", 32'h504, 3'd0);

        // call with ret: ret wins, no push; call with jump acts as call.
        step("call_ret", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 26'h300, 1'b1, 32'h600, 32'h600, 3'd0, em(1'b1));
        step("ret_empty", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h700, 32'h700, 3'd0, em(1'b1));
        step("call_jump", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 26'h10, 1'b0, 32'h0, 32'h40, ec(1), 1'b0);
        step("ret_cj", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h704, 32'h704, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
